display_scan_mux: RTL and testbench
===================================

Name: display_scan_mux

Overview:
- Time-multiplexed digit scanner for the six-digit HH:MM:SS clock display.
- Sits between the BCD time counters and the BCD-to-7-segment decoder.
- Each scan slot presents one BCD digit plus an enable to the decoder, and drives a one-hot digit-select to the common-cathode/anode drivers.
- Provides anti-ghosting blank time, tear-free frame latching, and hours-tens leading-zero suppression.

Parameters:
- REFRESH_DIV, 1000: clock cycles per digit slot; must be greater than BLANK_CYCLES.
- BLANK_CYCLES, 16: cycles at the start of each slot with all digits off; must be at least 1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- digits_in  input  24  packed BCD; [3:0]=sec ones, [7:4]=sec tens, [11:8]=min ones, [15:12]=min tens, [19:16]=hr ones, [23:20]=hr tens
- lz_blank  input  1  1 = suppress hours-tens digit when it is 0
- blink_mask  input  6  per-digit blink request; used only with BLINK_EN
- bcd_out  output  4  BCD digit to the decoder
- bcd_en  output  1  decoder enable; 0 = segments dark
- digit_sel  output  6  one-hot digit select; bit i = digit i
- frame_start  output  1  one-cycle pulse marking the start of each 6-digit frame

Behaviour:
- Interface: one clock `clk`; `rst_n` asynchronous active-low. All outputs registered. No combinational path from any input to any output.
- Reset values: bcd_out=0, bcd_en=0, digit_sel=0, frame_start=0, slot counter cnt=0, digit index idx=0, shadow register=0, state=BLANK.
- Counters:
  - cnt runs 0..REFRESH_DIV-1 and wraps to 0.
  - On wrap, idx increments 0..5; idx wraps 5 -> 0.
- State machine, derived from cnt:
  - BLANK (cnt < BLANK_CYCLES) -> SHOW when cnt reaches BLANK_CYCLES.
  - SHOW -> BLANK on cnt wrap.
- BLANK outputs: digit_sel=0, bcd_en=0, bcd_out holds its previous value.
- SHOW outputs:
  - digit_sel = 1 << idx.
  - bcd_out = shadow[4*idx+3 : 4*idx].
  - bcd_en = 1, except forced 0 when:
    - the digit value > 9, or
    - idx==5 and lz_blank==1 and the digit == 0.
- Output timing: outputs lag the cnt/idx state by one cycle (registered). After reset release, cycles 1..BLANK_CYCLES are dark. Digit 0 first shows on cycle BLANK_CYCLES+1.
- Frame latch:
  - The shadow register loads digits_in on the edge where cnt==0 and idx==0, including the first edge after reset release.
  - digits_in changes at any other time do not affect the frame in progress.
- frame_start: high for exactly the one cycle following each shadow load.
- Reset asserted mid-slot: all outputs go to their reset values immediately (asynchronous). The scan restarts from digit 0 with a fresh latch.
- Steady state: exactly one digit_sel bit may be high at any time. digit_sel is never nonzero in two consecutive slots without at least BLANK_CYCLES zero cycles between them.

Optional Feature:
- Macro: DISPLAY_SCAN_MUX_BLINK_EN.
- Defined:
  - A 6-bit frame counter fcnt increments on each frame_start; reset value 0.
  - In SHOW, if blink_mask[idx]==1 and fcnt[5]==1, bcd_en is forced 0. digit_sel still asserts.
  - blink_mask is sampled live, not latched.
- Not defined: blink_mask is ignored, fcnt is absent, and behaviour is exactly as above.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset, then digits_in=24'h123456, lz_blank=0 -> per 8-cycle slot, 2 dark cycles then 6 cycles with digit_sel=000001/bcd_out=6, 000010/5, 000100/4, 001000/3, 010000/2, 100000/1; bcd_en=1 throughout SHOW; frame_start pulses every 48 cycles.
- digits_in=24'h012345, lz_blank=1 -> slot 5 shows digit_sel=100000, bcd_en=0. With lz_blank=0 -> bcd_en=1, bcd_out=0.
- Change digits_in from 24'h111111 to 24'h999999 during slot 3 -> remaining slots of the frame still show 1. The next frame shows 9 on all digits.
- digits_in digit 2 = 4'hC -> slot 2 shows bcd_en=0 with digit_sel=000100.
- rst_n pulsed low at cycle 20 (mid slot 2) -> all outputs 0 within the same cycle. After release, scan restarts at digit 0 with a new latch and a frame_start pulse.
- With DISPLAY_SCAN_MUX_BLINK_EN, blink_mask=6'b000011 -> digits 0–1 dark for frames 32–63 of each 64-frame period; all other digits unaffected.

Source files
------------

// File: rtl/display_scan_mux.sv
// Six-digit HH:MM:SS scan multiplexer: per-slot blanking, frame-latched digits, hours-tens zero suppression.
// Optional per-digit blinking is compiled in with DISPLAY_SCAN_MUX_BLINK_EN.
module display_scan_mux #(
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] digits_in,
   input  logic        lz_blank,
   input  logic [5:0]  blink_mask,
   output logic [3:0]  bcd_out,
   output logic        bcd_en,
   output logic [5:0]  digit_sel,
   output logic        frame_start
);
   localparam int CW = $clog2(REFRESH_DIV);

   typedef enum logic {BLANK, SHOW} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [23:0]   shadow_q;
   logic [3:0]    bcd_q;
   logic          en_q, fs_q;
   logic [5:0]    sel_q;

   logic          wrap, load, blink_off, en_ok;
   logic [3:0]    digit;

   assign wrap  = (cnt_q == CW'(REFRESH_DIV - 1));
   assign load  = (cnt_q == '0) && (idx_q == 3'd0);
   assign cnt_d = wrap ? '0 : cnt_q + CW'(1);
   assign idx_d = !wrap ? idx_q : (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
   assign digit = shadow_q[{idx_q, 2'b00} +: 4];

`ifdef DISPLAY_SCAN_MUX_BLINK_EN
   logic [5:0] fcnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     fcnt_q <= '0;
      else if (fs_q)  fcnt_q <= fcnt_q + 6'd1;
   end
   // blink_mask is live so that edits show up mid-frame
   assign blink_off = blink_mask[idx_q] && fcnt_q[5];
`else
   logic unused_blink;
   assign unused_blink = ^blink_mask;
   assign blink_off    = 1'b0;
`endif

   assign en_ok = (digit <= 4'd9) && !blink_off &&
                  !((idx_q == 3'd5) && lz_blank && (digit == 4'd0));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= BLANK;
         cnt_q    <= '0;
         idx_q    <= '0;
         shadow_q <= '0;
         bcd_q    <= '0;
         en_q     <= 1'b0;
         sel_q    <= '0;
         fs_q     <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         fs_q  <= load;
         if (load) shadow_q <= digits_in;
         case (state_q)
            BLANK: begin
               sel_q <= '0;
               en_q  <= 1'b0;
               if (cnt_q == CW'(BLANK_CYCLES - 1)) state_q <= SHOW;
            end
            SHOW: begin
               sel_q <= 6'b1 << idx_q;
               bcd_q <= digit;
               en_q  <= en_ok;
               if (wrap) state_q <= BLANK;
            end
            default: state_q <= BLANK;
         endcase
      end
   end

   assign bcd_out     = bcd_q;
   assign bcd_en      = en_q;
   assign digit_sel   = sel_q;
   assign frame_start = fs_q;
endmodule

// File: tb/tb_display_scan_mux.sv
// Randomized bench for display_scan_mux against a cycle-count reference model (REFRESH_DIV=8, BLANK_CYCLES=2).
module tb_display_scan_mux;
   localparam int R = 8;
   localparam int B = 2;
   localparam int F = 6 * R;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [23:0] digits_in = 24'h123456;
   logic        lz_blank = 1'b0;
   logic [5:0]  blink_mask = 6'b000011;
   logic [3:0]  bcd_out;
   logic        bcd_en;
   logic [5:0]  digit_sel;
   logic        frame_start;

   display_scan_mux #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
      .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .lz_blank(lz_blank),
      .blink_mask(blink_mask), .bcd_out(bcd_out), .bcd_en(bcd_en),
      .digit_sel(digit_sel), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int          nvec = 0;
   int          nerr = 0;
   int          t = 0;          // edges since reset release
   logic [23:0] lat = '0;
   logic [3:0]  exp_bcd = '0;

   task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s t=%0d got{fs,sel,en,bcd}=%h exp=%h", tag, t, got, exp);
      end
   endtask

   // One clock: model what the edge about to happen should produce, then compare.
   task automatic step(input string tag);
      int         cnt, idx, fc;
      logic [5:0] sel;
      logic       en, fs;
      logic [3:0] d;
      cnt = t % R;
      idx = (t / R) % 6;
      fs  = (t % F == 0);
      if (fs) lat = digits_in;
      sel = '0;
      en  = 1'b0;
      if (cnt >= B) begin
         d       = lat[4*idx +: 4];
         exp_bcd = d;
         sel     = 6'b1 << idx;
         en      = (d < 4'd10) && !(idx == 5 && lz_blank && d == 4'd0);
`ifdef DISPLAY_SCAN_MUX_BLINK_EN
         fc = (t >= 2) ? (((t - 2) / F + 1) % 64) : 0;
         if (blink_mask[idx] && fc >= 32) en = 1'b0;
`else
         fc = 0;
`endif
      end
      @(posedge clk);
      #1;
      chk(tag, {frame_start, digit_sel, bcd_en, bcd_out}, {fs, sel, en, exp_bcd});
      t++;
   endtask

   task automatic run(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic align(input string tag);
      for (int i = 0; i < F && (t % F) != 0; i++) step(tag);
   endtask

   // Called just after an edge; asserts reset mid-cycle and checks it acts without a clock.
   task automatic pulse_reset();
      #3 rst_n = 1'b0;
      #1 chk("async_rst", {frame_start, digit_sel, bcd_en, bcd_out}, 12'h000);
      @(negedge clk);
      rst_n   = 1'b1;
      t       = 0;
      exp_bcd = '0;
   endtask

   function automatic logic [23:0] rand_digits();
      logic [23:0] v;
      for (int i = 0; i < 6; i++)
         v[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) v[23:20] = 4'd0;
      return v;
   endfunction

   initial begin
      #12;
      chk("reset_vals", {frame_start, digit_sel, bcd_en, bcd_out}, 12'h000);
      @(negedge clk);
      rst_n = 1'b1;
      run("basic_123456", 2 * F);

      digits_in = 24'h012345;
      lz_blank  = 1'b1;
      run("lz_on", 2 * F);
      lz_blank  = 1'b0;
      run("lz_off", F);

      digits_in = 24'h111111;
      align("pre_tear");
      run("tear_a", F + 3 * R + 3);
      digits_in = 24'h999999;
      run("tear_b", 2 * F);

      digits_in = 24'h123C56;
      run("invalid_bcd", 2 * F);

      align("pre_rst");
      run("mid_slot2", 20);
      pulse_reset();
      run("after_rst", 2 * F);

      for (int i = 0; i < 1200; i++) begin
         if ($urandom_range(0, 7) == 0) digits_in = rand_digits();
         if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
         if ($urandom_range(0, 99) == 0) blink_mask = 6'($urandom);
         step("rand_rst");
         if ($urandom_range(0, 299) == 0) pulse_reset();
      end
      pulse_reset();
      for (int i = 0; i < 3400; i++) begin
         if ($urandom_range(0, 7) == 0) digits_in = rand_digits();
         if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
         if ($urandom_range(0, 199) == 0) blink_mask = 6'($urandom);
         step("rand_long");
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
